// File: rtl/axi_rd_pkg.sv
// Shared types for the AXI4 read responder: burst/resp encodings, FSM states, AR request.
// The AR struct is sized for the default port widths; narrower ports are zero-extended into it.
package axi_rd_pkg;

    localparam int AR_ID_W   = 4;
    localparam int AR_ADDR_W = 32;

    typedef enum logic [1:0] {
        FIXED = 2'b00,
        INCR  = 2'b01,
        WRAP  = 2'b10,
        RSVD  = 2'b11
    } burst_t;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    typedef struct packed {
        logic [AR_ID_W-1:0]   id;
        logic [AR_ADDR_W-1:0] addr;
        logic [7:0]           len;
        logic [2:0]           size;
        burst_t               burst;
    } ar_req_t;

    function automatic logic wrap_len_ok(input logic [7:0] len);
        return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    endfunction

endpackage

// File: rtl/axi_fifo.sv
// Small synchronous FIFO with registered count; DEPTH must equal 2**PTR_WIDTH.
module axi_fifo #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 4,
    parameter int PTR_WIDTH = 2
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0]   mem [DEPTH];
    logic [PTR_WIDTH-1:0] wr_ptr;
    logic [PTR_WIDTH-1:0] rd_ptr;
    logic [PTR_WIDTH:0]   count;
    logic                 do_push;
    logic                 do_pop;

    assign full    = (count == (PTR_WIDTH+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_WIDTH'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_WIDTH'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (PTR_WIDTH+1)'(1);
                2'b01:   count <= count - (PTR_WIDTH+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is not reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/axi_rd_responder.sv
// AXI4 read responder: queued AR requests, word memory with backdoor write, R burst engine.
// Define AXI_RD_WRAP_EN to support WRAP bursts; otherwise WRAP is answered as an error burst.
//
// state | meaning
// IDLE  | no burst active; pops the queue head and loads beat 0 when one is waiting
// BURST | presenting beats; returns to IDLE once the rlast beat is accepted
module axi_rd_responder #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int ID_WIDTH     = 4,
    parameter int MEM_DEPTH    = 256,
    parameter int AR_DEPTH     = 4,
    parameter int AR_PTR_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [ID_WIDTH-1:0]   arid,
    input  logic [ADDR_WIDTH-1:0] araddr,
    input  logic [7:0]            arlen,
    input  logic [2:0]            arsize,
    input  logic [1:0]            arburst,
    input  logic                  arvalid,
    output logic                  arready,
    output logic [ID_WIDTH-1:0]   rid,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [1:0]            rresp,
    output logic                  rlast,
    output logic                  rvalid,
    input  logic                  rready,
    input  logic                  mem_we,
    input  logic [ADDR_WIDTH-1:0] mem_waddr,
    input  logic [DATA_WIDTH-1:0] mem_wdata
);

    import axi_rd_pkg::*;

    localparam int BYTES  = DATA_WIDTH / 8;
    localparam int IDX_LO = $clog2(BYTES);
    localparam int MEM_AW = $clog2(MEM_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] BYTE_STEP  = ADDR_WIDTH'(BYTES);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(BYTES - 1);
    localparam logic [2:0]            NATIVE_SIZE = 3'(IDX_LO);

    function automatic logic [MEM_AW-1:0] word_idx(input logic [ADDR_WIDTH-1:0] a);
        return MEM_AW'(a >> IDX_LO);
    endfunction

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    ar_req_t               ar_in;
    ar_req_t               head;
    logic                  q_push;
    logic                  q_pop;
    logic                  q_full;
    logic                  q_empty;

    state_t                state;
    state_t                state_nxt;
    logic [7:0]            beat_cnt;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH-1:0] addr_nxt;
    logic [ADDR_WIDTH-1:0] start_addr;
    burst_t                burst_q;
    logic                  err_q;
    logic                  start_err;
    logic                  beat_adv;
`ifdef AXI_RD_WRAP_EN
    logic [ADDR_WIDTH-1:0] wrap_mask_q;
`endif

    always_comb begin
        ar_in.id    = AR_ID_W'(arid);
        ar_in.addr  = AR_ADDR_W'(araddr);
        ar_in.len   = arlen;
        ar_in.size  = arsize;
        ar_in.burst = burst_t'(arburst);
    end

    assign arready = !q_full;
    assign q_push  = arvalid && arready;

    axi_fifo #(
        .WIDTH     ($bits(ar_req_t)),
        .DEPTH     (AR_DEPTH),
        .PTR_WIDTH (AR_PTR_WIDTH)
    ) u_ar_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (q_push),
        .din    (ar_in),
        .pop    (q_pop),
        .dout   (head),
        .full   (q_full),
        .empty  (q_empty)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (!q_empty) state_nxt = BURST;
            BURST:   if (rready && (beat_cnt == 8'd0)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        rvalid   = (state == BURST);
        rlast    = rvalid && (beat_cnt == 8'd0);
        q_pop    = (state == IDLE) && !q_empty;
        beat_adv = rvalid && rready && !rlast;
    end

    assign start_addr = ADDR_WIDTH'(head.addr) & ALIGN_MASK;

    always_comb begin
        start_err = (head.size != NATIVE_SIZE);
        case (head.burst)
            RSVD:    start_err = 1'b1;
`ifdef AXI_RD_WRAP_EN
            WRAP:    if (!wrap_len_ok(head.len)) start_err = 1'b1;
`else
            WRAP:    start_err = 1'b1;
`endif
            default: ;
        endcase
    end

    always_comb begin
        addr_nxt = addr_q;
        case (burst_q)
            INCR:    addr_nxt = addr_q + BYTE_STEP;
`ifdef AXI_RD_WRAP_EN
            // Wrap lengths are powers of two, so the boundary is a simple bit mask.
            WRAP:    addr_nxt = (addr_q & ~wrap_mask_q) | ((addr_q + BYTE_STEP) & wrap_mask_q);
`endif
            default: addr_nxt = addr_q;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            beat_cnt    <= 8'd0;
            addr_q      <= '0;
            burst_q     <= FIXED;
            err_q       <= 1'b0;
            rid         <= '0;
            rdata       <= '0;
            rresp       <= OKAY;
`ifdef AXI_RD_WRAP_EN
            wrap_mask_q <= '0;
`endif
        end else if (q_pop) begin
            beat_cnt    <= head.len;
            addr_q      <= start_addr;
            burst_q     <= head.burst;
            err_q       <= start_err;
            rid         <= ID_WIDTH'(head.id);
            rdata       <= start_err ? '0 : mem[word_idx(start_addr)];
            rresp       <= start_err ? SLVERR : OKAY;
`ifdef AXI_RD_WRAP_EN
            wrap_mask_q <= (ADDR_WIDTH'(head.len) << IDX_LO) | ADDR_WIDTH'(BYTES - 1);
`endif
        end else if (beat_adv) begin
            beat_cnt <= beat_cnt - 8'd1;
            addr_q   <= addr_nxt;
            rdata    <= err_q ? '0 : mem[word_idx(addr_nxt)];
        end
    end

    // Memory survives reset so preloaded contents outlive a mid-test reset.
    always_ff @(posedge clk) begin
        if (mem_we) mem[word_idx(mem_waddr)] <= mem_wdata;
    end

endmodule

// File: tb/tb_axi_rd_responder.sv
// Bench for axi_rd_responder: directed scenarios plus randomized traffic against a burst-level model.
module tb_axi_rd_responder;

    localparam int DEPTH = 256;

    logic        clk = 1'b0;
    logic        resetn = 1'b1;
    logic [3:0]  arid = '0;
    logic [31:0] araddr = '0;
    logic [7:0]  arlen = '0;
    logic [2:0]  arsize = '0;
    logic [1:0]  arburst = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready = 1'b0;
    logic        mem_we = 1'b0;
    logic [31:0] mem_waddr = '0;
    logic [31:0] mem_wdata = '0;

    axi_rd_responder dut (
        .clk       (clk),
        .resetn    (resetn),
        .arid      (arid),
        .araddr    (araddr),
        .arlen     (arlen),
        .arsize    (arsize),
        .arburst   (arburst),
        .arvalid   (arvalid),
        .arready   (arready),
        .rid       (rid),
        .rdata     (rdata),
        .rresp     (rresp),
        .rlast     (rlast),
        .rvalid    (rvalid),
        .rready    (rready),
        .mem_we    (mem_we),
        .mem_waddr (mem_waddr),
        .mem_wdata (mem_wdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  id;
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } beat_t;

    beat_t       exp_q[$];
    logic [31:0] mem_m [DEPTH];
    int          n_checks = 0;
    int          n_fail = 0;
    int          ar_acc = 0;
    int          r_beats = 0;
    int          rr_mode = 0;
    bit          qf_done = 1'b0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected beats for one accepted AR, straight from the burst addressing rules.
    task automatic ref_accept(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                              input logic [2:0] size, input logic [1:0] burst);
        bit          err;
        bit [31:0]   a0, bt, base, a;
        beat_t       b;
        err = (size != 3'd2) || (burst == 2'b11);
`ifdef AXI_RD_WRAP_EN
        if (burst == 2'b10 && !(len == 1 || len == 3 || len == 7 || len == 15)) err = 1'b1;
`else
        if (burst == 2'b10) err = 1'b1;
`endif
        a0 = addr & ~32'h3;
        for (int i = 0; i <= int'(len); i++) begin
            case (burst)
                2'b00:   a = a0;
                2'b01:   a = a0 + 32'(i * 4);
                default: begin
                    bt   = (32'(len) + 1) * 4;
                    base = (a0 / bt) * bt;
                    a    = base + ((a0 - base + 32'(i * 4)) % bt);
                end
            endcase
            b.id   = id;
            b.data = err ? 32'h0 : mem_m[(a >> 2) % DEPTH];
            b.resp = err ? 2'b10 : 2'b00;
            b.last = (i == int'(len));
            exp_q.push_back(b);
        end
    endtask

    // rready driver: 0 always high, 1 random, 2 held low, other values leave it to the test
    initial forever begin
        @(posedge clk);
        #1;
        case (rr_mode)
            0:       rready = 1'b1;
            1:       rready = 1'($urandom_range(0, 1));
            2:       rready = 1'b0;
            default: ;
        endcase
    end

    // Monitor, sampling mid-cycle ahead of the next rising edge.
    initial begin
        bit stalled;
        stalled = 1'b0;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                stalled = 1'b0;
            end else begin
                if (stalled) check_val("rvalid_hold", rvalid, 1'b1);
                if (arvalid && arready) begin
                    ref_accept(arid, araddr, arlen, arsize, arburst);
                    ar_acc++;
                end
                if (exp_q.size() == 0) begin
                    check_val("spurious_rvalid", rvalid, 1'b0);
                end else if (rvalid) begin
                    check_val("rid", rid, exp_q[0].id);
                    check_val("rdata", rdata, exp_q[0].data);
                    check_val("rresp", rresp, exp_q[0].resp);
                    check_val("rlast", rlast, exp_q[0].last);
                    if (rready) begin
                        void'(exp_q.pop_front());
                        r_beats++;
                    end
                end
                stalled = rvalid && !rready;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_ar(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        bit hs;
        int n;
        n = 0;
        arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst;
        arvalid = 1'b1;
        do begin
            @(negedge clk);
            hs = arready;
            @(posedge clk);
            #1;
            n++;
        end while (!hs && n < 3000);
        arvalid = 1'b0;
        check_val("ar_accept", hs, 1'b1);
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || rvalid || arvalid) && n < 5000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_val(tag, n < 5000, 1'b1);
    endtask

    task automatic backdoor(input logic [31:0] addr, input logic [31:0] data);
        mem_we = 1'b1; mem_waddr = addr; mem_wdata = data;
        tick(1);
        mem_we = 1'b0;
        mem_m[(addr >> 2) % DEPTH] = data;
    endtask

    task automatic random_traffic(input int count);
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        for (int k = 0; k < count; k++) begin
            addr  = ($urandom_range(0, 7) == 0) ? $urandom() : 32'($urandom_range(0, 1023));
            size  = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7)) : 3'd2;
            burst = 2'($urandom_range(0, 3));
            len   = 8'($urandom_range(0, 15));
            if (burst == 2'b10 && $urandom_range(0, 4) != 0)
                len = 8'((1 << $urandom_range(1, 4)) - 1);
            send_ar(4'($urandom()), addr, len, size, burst);
            tick($urandom_range(0, 3));
        end
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, n;
        #2 resetn = 1'b0;
        #20;
        check_val("rst_rvalid", rvalid, 1'b0);
        check_val("rst_rlast", rlast, 1'b0);
        check_val("rst_rid", rid, 4'h0);
        check_val("rst_rdata", rdata, 32'h0);
        check_val("rst_rresp", rresp, 2'b00);
        check_val("rst_arready", arready, 1'b1);
        @(posedge clk); #3 resetn = 1'b1;
        tick(1);

        mem_we = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            mem_waddr = 32'(i * 4);
            mem_wdata = 32'hA000_0000 + 32'(i);
            mem_m[i]  = 32'hA000_0000 + 32'(i);
            tick(1);
        end
        mem_we = 1'b0;
        tick(2);

        // INCR with first-beat latency
        rr_mode = 0;
        send_ar(4'd5, 32'h10, 8'd3, 3'd2, 2'b01);
        @(negedge clk); check_val("incr_lat_k1", rvalid, 1'b0);
        @(negedge clk); check_val("incr_lat_k2", rvalid, 1'b1);
        wait_drain("incr_drain");

        send_ar(4'd3, 32'h38, 8'd3, 3'd2, 2'b10);
        wait_drain("wrap_drain");

        send_ar(4'd7, 32'h20, 8'd2, 3'd2, 2'b00);
        wait_drain("fixed_drain");

        // Backpressure on beat 2
        rr_mode = 3;
        rready = 1'b1;
        base = r_beats;
        send_ar(4'd9, 32'h40, 8'd3, 3'd2, 2'b01);
        n = 0;
        while (r_beats < base + 1 && n < 100) begin @(posedge clk); n++; end
        check_val("bp_first_beat", n < 100, 1'b1);
        #2 rready = 1'b0;
        repeat (3) @(posedge clk);
        #2 rready = 1'b1;
        wait_drain("bp_drain");
        check_val("bp_beats", 32'(r_beats - base), 32'd4);
        rr_mode = 0;

        // Queue full with R stalled
        rr_mode = 2;
        tick(2);
        base = ar_acc;
        qf_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 6; i++)
                    send_ar(4'(i + 1), 32'(i * 32), 8'd1, 3'd2, 2'b01);
                qf_done = 1'b1;
            end
        join_none
        tick(10);
        check_val("qf_accepted", 32'(ar_acc - base), 32'd5);
        check_val("qf_arready", arready, 1'b0);
        rr_mode = 0;
        n = 0;
        while (!qf_done && n < 200) begin tick(1); n++; end
        check_val("qf_done", qf_done, 1'b1);
        wait_drain("qf_drain");
        check_val("qf_total", 32'(ar_acc - base), 32'd6);

        // Error bursts
        send_ar(4'd2, 32'h0, 8'd1, 3'd1, 2'b01);
        wait_drain("err_size_drain");
        send_ar(4'd4, 32'h8, 8'd1, 3'd2, 2'b11);
        wait_drain("err_rsvd_drain");

        // Reset mid-burst
        send_ar(4'd6, 32'h100, 8'd15, 3'd2, 2'b01);
        tick(4);
        #2 resetn = 1'b0;
        #1;
        check_val("midrst_rvalid", rvalid, 1'b0);
        check_val("midrst_arready", arready, 1'b1);
        check_val("midrst_rlast", rlast, 1'b0);
        exp_q.delete();
        @(posedge clk); #3 resetn = 1'b1;
        tick(10);
        check_val("midrst_no_beats", rvalid, 1'b0);

        // Randomized traffic, then fresh backdoor contents and more traffic
        rr_mode = 1;
        random_traffic(60);
        wait_drain("rand1_drain");
        for (int i = 0; i < 16; i++)
            backdoor(32'($urandom_range(0, 1023)), $urandom());
        rr_mode = 0;
        random_traffic(10);
        rr_mode = 1;
        random_traffic(20);
        wait_drain("rand2_drain");

        tick(3);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
